// File: rtl/mem_stage_mc.sv
// rtl/mem_stage_mc.sv - multi-cycle MEM-stage data RAM with byte-lane stores, store-data forwarding,
// pipeline stall and out-of-range / illegal-op error reporting.
module mem_stage_mc #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                fwd_sel,
  input  logic [DATA_W-1:0]   fwd_data,
  output logic [DATA_W-1:0]   rdata,
  output logic                rdata_valid,
  output logic                wr_done,
  output logic                addr_err,
  output logic                stall
);
  localparam int LANES = DATA_W / 8;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LANES-1:0]  ben_q, ben_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              wr_done_q, wr_done_d;
  logic              addr_err_q, addr_err_d;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              accept;
  logic              complete;
  logic              in_range;
  logic              op_err;
  logic              ram_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] rd_word;

  assign accept   = ((state_q == S_IDLE) || (state_q == S_DONE)) && req_valid && (mem_read || mem_write);
  assign complete = (state_q == S_BUSY) && (cnt_q == '0);
  // Full-width compare so high address bits can never alias into the RAM.
  assign in_range = {1'b0, addr_q} < DEPTH_L;
  assign op_err   = (rd_q && wr_q) || !in_range;
  assign mem_idx  = addr_q[IDX_W-1:0];
  assign rd_word  = mem[mem_idx];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_d          = rd_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    ben_d         = ben_q;
    sdata_d       = sdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    wr_done_d     = 1'b0;
    addr_err_d    = 1'b0;
    ram_we        = 1'b0;
    case (state_q)
      S_BUSY: begin
        if (complete) begin
          state_d       = S_DONE;
          rdata_valid_d = rd_q;
          wr_done_d     = wr_q && !rd_q;
          addr_err_d    = op_err;
          ram_we        = wr_q && !rd_q && !op_err;
          if (rd_q) begin
            rdata_d = op_err ? '0 : rd_word;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Store data is sampled only here; upstream may change fwd_data while busy.
    if (accept) begin
      state_d = S_BUSY;
      cnt_d   = CNT_INIT;
      rd_d    = mem_read;
      wr_d    = mem_write;
      addr_d  = addr;
      ben_d   = byte_en;
      sdata_d = fwd_sel ? fwd_data : wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      ben_q         <= '0;
      sdata_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      wr_done_q     <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      ben_q         <= ben_d;
      sdata_q       <= sdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      wr_done_q     <= wr_done_d;
      addr_err_q    <= addr_err_d;
    end
  end

  // RAM is not reset; a reset on the completing edge drops the store.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (ben_q[i]) begin
          mem[mem_idx][8*i +: 8] <= sdata_q[8*i +: 8];
        end
      end
    end
  end

  assign stall       = accept || ((state_q == S_BUSY) && (cnt_q != '0));
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign wr_done     = wr_done_q;
  assign addr_err    = addr_err_q;
endmodule

// File: tb/tb_mem_stage_mc.sv
// tb/tb_mem_stage_mc.sv - self-checking bench for mem_stage_mc: directed vector table,
// randomized ops against a transaction-level RAM model, back-to-back and reset-mid-store sequences.
module tb_mem_stage_mc;
  localparam int LAT   = 3;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  byte_en = 2'b00;
  logic [15:0] addr = 16'h0;
  logic [15:0] wdata = 16'h0;
  logic        fwd_sel = 1'b0;
  logic [15:0] fwd_data = 16'h0;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        wr_done;
  logic        addr_err;
  logic        stall;

  mem_stage_mc #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
    .byte_en(byte_en), .addr(addr), .wdata(wdata), .fwd_sel(fwd_sel), .fwd_data(fwd_data),
    .rdata(rdata), .rdata_valid(rdata_valid), .wr_done(wr_done), .addr_err(addr_err), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] ref_mem [0:DEPTH-1];
  logic [15:0] ref_rdata = 16'h0;
  logic [15:0] m_rdata;
  logic        m_err;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [1:0]  be;
    logic [15:0] wd;
    logic        fs;
    logic [15:0] fd;
    logic [15:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: one whole operation at a time, no timing.
  task automatic model_op(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [1:0] be, input logic [15:0] sd);
    m_err = (rd || wr) && ((rd && wr) || (int'(a) >= DEPTH));
    if (rd) begin
      ref_rdata = m_err ? 16'h0 : ref_mem[a];
    end else if (wr && !m_err) begin
      for (int i = 0; i < 2; i++) begin
        if (be[i]) ref_mem[a][8*i +: 8] = sd[8*i +: 8];
      end
    end
    m_rdata = ref_rdata;
  endtask

  task automatic run_op(input string name, input logic rd, input logic wr, input logic [15:0] a,
                        input logic [1:0] be, input logic [15:0] wd, input logic fs,
                        input logic [15:0] fd, input logic [15:0] e_rdata, input logic e_err);
    int          stall_n;
    int          done_c;
    int          pulse_n;
    logic        is_op;
    logic        got_rv;
    logic        got_wd;
    logic        got_err;
    logic [15:0] got_rdata;
    is_op = rd || wr;
    stall_n = 0; done_c = -1; pulse_n = 0;
    got_rv = 1'b0; got_wd = 1'b0; got_err = 1'b0; got_rdata = 16'h0;
    @(negedge clk);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; addr = a; byte_en = be;
    wdata = wd; fwd_sel = fs; fwd_data = fd;
    #1;
    if (stall) stall_n++;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      wdata = ~wd; fwd_data = ~fd; addr = ~a;
      @(negedge clk);
      if (stall) stall_n++;
      if (rdata_valid || wr_done || addr_err) begin
        pulse_n++;
        if (done_c < 0) begin
          done_c = c; got_rv = rdata_valid; got_wd = wr_done; got_err = addr_err; got_rdata = rdata;
        end
      end
    end
    if (is_op) begin
      chk({name, "_stall_cycles"}, stall_n, LAT);
      chk({name, "_done_cycle"}, done_c, LAT + 1);
      chk({name, "_pulse_count"}, pulse_n, 1);
      chk({name, "_rdata_valid"}, got_rv, rd);
      chk({name, "_wr_done"}, got_wd, wr && !rd);
      chk({name, "_addr_err"}, got_err, e_err);
      chk({name, "_rdata"}, got_rdata, e_rdata);
    end else begin
      chk({name, "_nop_stall"}, stall_n, 0);
      chk({name, "_nop_pulses"}, pulse_n, 0);
      chk({name, "_nop_rdata"}, rdata, e_rdata);
    end
  endtask

  initial begin
    logic        rd, wr, fs;
    logic [15:0] a, wd, fd;
    logic [1:0]  be;
    int          r;

    //          rd  wr  addr      be     wdata     fs  fwd_data  exp_rdata  exp_err
    vecs[0]  = '{0, 1, 16'h0000, 2'b11, 16'h0F0F, 0, 16'h0000, 16'h0000, 0};
    vecs[1]  = '{0, 1, 16'h0010, 2'b11, 16'hBEEF, 0, 16'h0000, 16'h0000, 0};
    vecs[2]  = '{1, 0, 16'h0010, 2'b11, 16'h0000, 0, 16'h0000, 16'hBEEF, 0};
    vecs[3]  = '{0, 1, 16'h0005, 2'b11, 16'h1234, 0, 16'h0000, 16'hBEEF, 0};
    vecs[4]  = '{0, 1, 16'h0005, 2'b10, 16'hAB00, 0, 16'h0000, 16'hBEEF, 0};
    vecs[5]  = '{1, 0, 16'h0005, 2'b00, 16'h0000, 0, 16'h0000, 16'hAB34, 0};
    vecs[6]  = '{0, 1, 16'h0007, 2'b11, 16'h1111, 1, 16'h2222, 16'hAB34, 0};
    vecs[7]  = '{1, 0, 16'h0007, 2'b11, 16'h0000, 0, 16'h0000, 16'h2222, 0};
    vecs[8]  = '{1, 0, 16'h0100, 2'b11, 16'h0000, 0, 16'h0000, 16'h0000, 1};
    vecs[9]  = '{0, 1, 16'h0100, 2'b11, 16'hDEAD, 0, 16'h0000, 16'h0000, 1};
    vecs[10] = '{1, 0, 16'h0000, 2'b11, 16'h0000, 0, 16'h0000, 16'h0F0F, 0};
    vecs[11] = '{1, 1, 16'h0010, 2'b11, 16'h7777, 0, 16'h0000, 16'h0000, 1};
    vecs[12] = '{1, 0, 16'h0010, 2'b11, 16'h0000, 0, 16'h0000, 16'hBEEF, 0};
    vecs[13] = '{0, 0, 16'h0010, 2'b11, 16'h5A5A, 0, 16'h0000, 16'hBEEF, 0};
    vecs[14] = '{0, 1, 16'h0009, 2'b11, 16'h0000, 0, 16'h0000, 16'hBEEF, 0};
    vecs[15] = '{1, 0, 16'hFFFF, 2'b11, 16'h0000, 0, 16'h0000, 16'h0000, 1};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rdata", rdata, 16'h0);
    chk("reset_rdata_valid", rdata_valid, 1'b0);
    chk("reset_wr_done", wr_done, 1'b0);
    chk("reset_addr_err", addr_err, 1'b0);
    chk("reset_stall", stall, 1'b0);

    foreach (vecs[i]) begin
      model_op(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].be, vecs[i].fs ? vecs[i].fd : vecs[i].wd);
      run_op($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].be, vecs[i].wd,
             vecs[i].fs, vecs[i].fd, vecs[i].e_rdata, vecs[i].e_err);
    end

    for (int i = 0; i < 32; i++) begin
      wd = 16'($urandom);
      model_op(1'b0, 1'b1, 16'(i), 2'b11, wd);
      run_op($sformatf("init%0d", i), 1'b0, 1'b1, 16'(i), 2'b11, wd, 1'b0, 16'h0, m_rdata, m_err);
    end

    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 4) || (r == 8);
      wr = (r >= 4) && (r <= 8);
      a  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 31));
      be = 2'($urandom_range(0, 3));
      wd = 16'($urandom);
      fd = 16'($urandom);
      fs = 1'($urandom_range(0, 1));
      model_op(rd, wr, a, be, fs ? fd : wd);
      run_op($sformatf("rand%0d", i), rd, wr, a, be, wd, fs, fd, m_rdata, m_err);
    end

    // Back-to-back: a load held on the inputs throughout the store is accepted in DONE.
    model_op(1'b0, 1'b1, 16'd20, 2'b11, 16'h4321);
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; addr = 16'd20; byte_en = 2'b11;
    wdata = 16'h4321; fwd_sel = 1'b0;
    #1 chk("b2b_stall_c0", stall, 1'b1);
    for (int c = 1; c <= 2 * LAT + 2; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        mem_read = 1'b1; mem_write = 1'b0; wdata = 16'h0;
      end
      if (c == LAT + 2) begin
        req_valid = 1'b0; mem_read = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("b2b_stall_c%0d", c), stall, (c <= 2 * LAT + 1) && ((c % (LAT + 1)) != LAT));
      chk($sformatf("b2b_wr_done_c%0d", c), wr_done, c == LAT + 1);
      chk($sformatf("b2b_rdata_valid_c%0d", c), rdata_valid, c == 2 * LAT + 2);
      if (c == 2 * LAT + 2) chk("b2b_rdata", rdata, 16'h4321);
    end
    model_op(1'b1, 1'b0, 16'd20, 2'b11, 16'h0);

    // Reset while a store to addr 9 is still counting down.
    model_op(1'b0, 1'b1, 16'd9, 2'b11, 16'h0000);
    run_op("clear9", 1'b0, 1'b1, 16'd9, 2'b11, 16'h0000, 1'b0, 16'h0, m_rdata, m_err);
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; addr = 16'd9; byte_en = 2'b11;
    wdata = 16'h5555; fwd_sel = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0; mem_write = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_rdata", rdata, 16'h0);
    chk("midrst_rdata_valid", rdata_valid, 1'b0);
    chk("midrst_wr_done", wr_done, 1'b0);
    chk("midrst_addr_err", addr_err, 1'b0);
    chk("midrst_stall", stall, 1'b0);
    ref_rdata = 16'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("midrst_no_wr_done_c%0d", c), wr_done, 1'b0);
      chk($sformatf("midrst_no_stall_c%0d", c), stall, 1'b0);
    end
    model_op(1'b1, 1'b0, 16'd9, 2'b11, 16'h0);
    run_op("midrst_load9", 1'b1, 1'b0, 16'd9, 2'b11, 16'h0, 1'b0, 16'h0, m_rdata, m_err);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
